// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory load controller.
// Optional fetch bounds checking in imem_load_ctrl is enabled by IMEM_BOUNDS_CHK_EN.
package imem_ctrl_pkg;

    localparam int unsigned IMEM_DEPTH     = 64;
    localparam int unsigned IMEM_IDX_W     = $clog2(IMEM_DEPTH);
    localparam logic [31:0] IMEM_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StLoad  = 2'd1,
        StFlush = 2'd2
    } imem_state_e;

endpackage

// File: rtl/imem_load_ctrl.sv
// Arbitrates the single-port instruction memory between core fetch and a loader stream.
// Define IMEM_BOUNDS_CHK_EN to trap misaligned or out-of-range fetch addresses in RUN.
module imem_load_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH     = IMEM_DEPTH,
    parameter int unsigned IDX_W     = IMEM_IDX_W,
    parameter logic [31:0] NOP_INSTR = IMEM_NOP_INSTR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_start,
    input  logic [IDX_W:0]   load_count,
    input  logic             ld_valid,
    input  logic [31:0]      ld_data,
    output logic             ld_ready,
    input  logic [31:0]      core_pc,
    output logic [31:0]      core_instr,
    output logic             core_stall,
    output logic             core_restart,
    output logic [31:0]      imem_addr,
    output logic             imem_we,
    output logic [31:0]      imem_wdata,
    input  logic [31:0]      imem_instr,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

    imem_state_e      r_state;
    imem_state_e      w_state_next;
    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] w_wr_idx_next;
    logic [IDX_W:0]   r_count;
    logic [IDX_W:0]   w_count_next;
    logic             r_err;
    logic             w_err_next;

    logic             w_count_ok;
    logic             w_last;

`ifdef IMEM_BOUNDS_CHK_EN
    logic             w_pc_bad;
    assign w_pc_bad = (core_pc[31:2] >= 30'(DEPTH)) || (core_pc[1:0] != 2'b00);
`endif

    assign w_count_ok = (load_count != '0) && (load_count <= DEPTH_L);
    assign w_last     = ({1'b0, r_wr_idx} == (r_count - (IDX_W + 1)'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StRun;
            r_wr_idx <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_wr_idx <= w_wr_idx_next;
            r_count  <= w_count_next;
            r_err    <= w_err_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_wr_idx_next = r_wr_idx;
        w_count_next  = r_count;
        w_err_next    = r_err;
        ld_ready      = 1'b0;
        core_stall    = 1'b0;
        core_restart  = 1'b0;
        done          = 1'b0;
        imem_we       = 1'b0;
        imem_wdata    = '0;
        imem_addr     = '0;
        core_instr    = imem_instr;

        unique case (r_state)
            StRun: begin
                imem_addr  = core_pc;
                core_instr = imem_instr;
`ifdef IMEM_BOUNDS_CHK_EN
                if (w_pc_bad) begin
                    imem_addr  = '0;
                    core_instr = NOP_INSTR;
                    w_err_next = 1'b1;
                end
`endif
                if (load_start) begin
                    if (w_count_ok) begin
                        w_count_next  = load_count;
                        w_wr_idx_next = '0;
                        w_state_next  = StLoad;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end

            StLoad: begin
                ld_ready   = 1'b1;
                core_stall = 1'b1;
                core_instr = NOP_INSTR;
                imem_addr  = {{(30 - IDX_W){1'b0}}, r_wr_idx, 2'b00};
                imem_wdata = ld_data;
                // Reset must win over a write that would land on the same edge.
                imem_we    = ld_valid && !reset;
                if (ld_valid) begin
                    if (w_last) begin
                        w_wr_idx_next = '0;
                        w_state_next  = StFlush;
                    end else begin
                        w_wr_idx_next = r_wr_idx + IDX_W'(1);
                    end
                end
            end

            StFlush: begin
                core_stall   = 1'b1;
                core_instr   = NOP_INSTR;
                core_restart = 1'b1;
                done         = 1'b1;
                w_state_next = StRun;
            end

            default: begin
                w_state_next = StRun;
            end
        endcase
    end

    assign busy = (r_state != StRun);
    assign err  = r_err;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed self-checking bench for imem_load_ctrl with a small behavioural memory model.
module tb_imem_load_ctrl;

    logic        clk;
    logic        reset;
    logic        load_start;
    logic [6:0]  load_count;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic [31:0] core_pc;
    logic [31:0] core_instr;
    logic        core_stall;
    logic        core_restart;
    logic [31:0] imem_addr;
    logic        imem_we;
    logic [31:0] imem_wdata;
    logic [31:0] imem_instr;
    logic        busy;
    logic        done;
    logic        err;

    logic [31:0] mem [64];

    int n_run;
    int n_fail;

    imem_load_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .load_count   (load_count),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_ready     (ld_ready),
        .core_pc      (core_pc),
        .core_instr   (core_instr),
        .core_stall   (core_stall),
        .core_restart (core_restart),
        .imem_addr    (imem_addr),
        .imem_we      (imem_we),
        .imem_wdata   (imem_wdata),
        .imem_instr   (imem_instr),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: reset restores a boot image of 0x1000+index.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000 + i;
        end else if (imem_we) begin
            mem[imem_addr[7:2]] <= imem_wdata;
        end
    end
    assign imem_instr = mem[imem_addr[7:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [5:0]  pat;
        int          n_busy;
        int          n_wr;
        int          n_done;
        logic [31:0] wr_addr [2];

        n_run      = 0;
        n_fail     = 0;
        reset      = 1'b1;
        load_start = 1'b0;
        load_count = '0;
        ld_valid   = 1'b0;
        ld_data    = '0;
        core_pc    = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_busy",    busy,         0);
        chk("rst_stall",   core_stall,   0);
        chk("rst_ready",   ld_ready,     0);
        chk("rst_we",      imem_we,      0);
        chk("rst_done",    done,         0);
        chk("rst_restart", core_restart, 0);
        chk("rst_err",     err,          0);

        // RUN passthrough
        core_pc = 32'h08;
        #1;
        chk("run_addr",  imem_addr,  32'h08);
        chk("run_instr", core_instr, 32'h1002);
        chk("run_stall", core_stall, 0);

        // Three-word load, ld_valid held high
        tick();
        load_start = 1'b1;
        load_count = 7'd3;
        ld_valid   = 1'b1;
        ld_data    = 32'hA;
        #1;
        chk("l3_start_we",   imem_we, 0);
        chk("l3_start_busy", busy,    0);
        tick();
        load_start = 1'b0;
        #1;
        chk("l3_w0_we",    imem_we,    1);
        chk("l3_w0_addr",  imem_addr,  32'h0);
        chk("l3_w0_data",  imem_wdata, 32'hA);
        chk("l3_w0_ready", ld_ready,   1);
        chk("l3_w0_stall", core_stall, 1);
        chk("l3_w0_nop",   core_instr, 32'h13);
        chk("l3_w0_busy",  busy,       1);
        tick();
        ld_data = 32'hB;
        #1;
        chk("l3_w1_we",   imem_we,   1);
        chk("l3_w1_addr", imem_addr, 32'h4);
        tick();
        ld_data = 32'hC;
        #1;
        chk("l3_w2_we",   imem_we,   1);
        chk("l3_w2_addr", imem_addr, 32'h8);
        tick();
        ld_valid = 1'b0;
        #1;
        chk("fl_done",    done,         1);
        chk("fl_restart", core_restart, 1);
        chk("fl_we",      imem_we,      0);
        chk("fl_ready",   ld_ready,     0);
        chk("fl_addr",    imem_addr,    32'h0);
        chk("fl_stall",   core_stall,   1);
        chk("fl_busy",    busy,         1);
        tick();
        core_pc = 32'h0;
        #1;
        chk("post_done",  done,       0);
        chk("post_busy",  busy,       0);
        chk("post_stall", core_stall, 0);
        chk("post_w0",    core_instr, 32'hA);
        core_pc = 32'h4;
        #1;
        chk("post_w1", core_instr, 32'hB);
        core_pc = 32'h8;
        #1;
        chk("post_w2", core_instr, 32'hC);

        // Two-word load with gaps in ld_valid
        tick();
        load_start = 1'b1;
        load_count = 7'd2;
        tick();
        load_start = 1'b0;
        pat    = 6'b001001;
        n_busy = 0;
        n_wr   = 0;
        n_done = 0;
        for (int k = 0; k < 6; k++) begin
            ld_valid = pat[k];
            ld_data  = 32'h20 + k;
            #1;
            if (busy) n_busy++;
            if (done) n_done++;
            if (imem_we) begin
                if (n_wr < 2) wr_addr[n_wr] = imem_addr;
                n_wr++;
            end
            tick();
        end
        ld_valid = 1'b0;
        chk("gap_busy_cycles", n_busy,     5);
        chk("gap_writes",      n_wr,       2);
        chk("gap_addr0",       wr_addr[0], 32'h0);
        chk("gap_addr1",       wr_addr[1], 32'h4);
        chk("gap_done",        n_done,     1);
        core_pc = 32'h4;
        #1;
        chk("gap_w1", core_instr, 32'h23);

        // Illegal counts
        load_start = 1'b1;
        load_count = 7'd0;
        tick();
        load_start = 1'b0;
        #1;
        chk("cnt0_err",  err,  1);
        chk("cnt0_busy", busy, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("err_cleared", err, 0);
        load_start = 1'b1;
        load_count = 7'd65;
        #1;
        chk("cnt65_we", imem_we, 0);
        tick();
        load_start = 1'b0;
        #1;
        chk("cnt65_err",  err,     1);
        chk("cnt65_busy", busy,    0);
        chk("cnt65_we2",  imem_we, 0);

        // Reset on the second word of a five-word load
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        load_start = 1'b1;
        load_count = 7'd5;
        ld_valid   = 1'b1;
        ld_data    = 32'hD0;
        tick();
        load_start = 1'b0;
        #1;
        chk("rl_w0_we", imem_we, 1);
        tick();
        ld_data = 32'hD1;
        reset   = 1'b1;
        #1;
        chk("rl_w1_addr", imem_addr, 32'h4);
        chk("rl_w1_we",   imem_we,   0);
        tick();
        reset = 1'b0;
        #1;
        chk("rl_busy",  busy,       0);
        chk("rl_stall", core_stall, 0);
        chk("rl_ready", ld_ready,   0);
        n_done = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (done) n_done++;
            tick();
        end
        chk("rl_no_done", n_done, 0);
        ld_valid = 1'b0;

        // Out-of-range fetch
        core_pc = 32'h100;
        #1;
`ifdef IMEM_BOUNDS_CHK_EN
        chk("oob_instr", core_instr, 32'h13);
        chk("oob_addr",  imem_addr,  32'h0);
        tick();
        chk("oob_err", err, 1);
`else
        chk("oob_addr", imem_addr, 32'h100);
        tick();
        chk("oob_err", err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Sequences the single-port instruction memory between two users: core instruction fetch (run mode) and a program loader stream (load mode).
- Muxes the memory's shared address/write port, holds the core stalled while loading, and issues a restart pulse when loading finishes.
- Sits between the core's PC/fetch path, the loader source (debug/UART bridge) and the 64-word instruction memory.

Parameters:
- DEPTH, 64, number of 32-bit instruction words in the memory
- IDX_W, 6, word-index width, equal to $clog2(DEPTH)
- NOP_INSTR, 32'h00000013, instruction returned to the core while it is stalled

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- load_start  in  1  one-cycle request to begin a load session
- load_count  in  IDX_W+1  number of words to load, 1..DEPTH, sampled on load_start
- ld_valid  in  1  loader word valid
- ld_data  in  32  loader instruction word
- ld_ready  out  1  controller accepts ld_data this cycle
- core_pc  in  32  byte address from the core PC
- core_instr  out  32  instruction delivered to the core
- core_stall  out  1  core must hold its PC and pipeline
- core_restart  out  1  one-cycle pulse: core reloads PC = 0
- imem_addr  out  32  byte address to the memory (word-aligned)
- imem_we  out  1  memory write enable
- imem_wdata  out  32  memory write data
- imem_instr  in  32  combinational read data from the memory
- busy  out  1  high in LOAD or FLUSH
- done  out  1  one-cycle pulse at the end of a load
- err  out  1  sticky error flag, cleared only by reset

Behaviour:
- States: RUN, LOAD, FLUSH. Reset enters RUN with wr_idx=0, err=0, and done, core_restart, ld_ready, imem_we and core_stall all 0.
- RUN:
  - imem_addr=core_pc, imem_we=0, core_instr=imem_instr, core_stall=0.
  - On load_start with 1<=load_count<=DEPTH: latch load_count, wr_idx<=0, next state LOAD.
  - On load_start with load_count==0 or load_count>DEPTH: set err, stay in RUN.
- LOAD:
  - ld_ready=1, core_stall=1, core_instr=NOP_INSTR.
  - imem_addr={wr_idx,2'b00} zero-extended to 32 bits, imem_wdata=ld_data, imem_we=ld_valid (combinational).
  - A word is accepted when ld_valid&&ld_ready; the write commits on that edge and wr_idx increments.
  - When the accepted word is number load_count (wr_idx==count-1 at acceptance), next state is FLUSH.
  - ld_valid low inserts idle cycles with no write and no index change.
  - load_start is ignored in LOAD and FLUSH.
- FLUSH (exactly 1 cycle):
  - ld_ready=0, imem_we=0, core_stall=1, core_instr=NOP_INSTR, imem_addr=0.
  - core_restart=1 and done=1 for this cycle; next state RUN.
  - The core's first fetch in RUN reads word 0 with the new contents.
- Latency: load of N words with ld_valid held high takes N cycles in LOAD, 1 in FLUSH, so busy is high for N+1 cycles.
- busy=(state!=RUN).
- Wrap: wr_idx never exceeds DEPTH-1 because load_count is range-checked.
- Reset during LOAD or FLUSH: return to RUN immediately; a partial load is discarded (the memory's own reset restores the boot image); no done pulse.
- load_start in the same cycle as reset: reset wins.

Optional Feature:
- Macro IMEM_BOUNDS_CHK_EN.
- Defined: in RUN, if core_pc[31:2]>=DEPTH or core_pc[1:0]!=0, then core_instr=NOP_INSTR, err is set (sticky) and imem_addr is forced to 0.
- Undefined: core_pc passes through unchecked and out-of-range fetches are undefined.

Decomposition:
- Package imem_ctrl_pkg: state enum typedef (RUN, LOAD, FLUSH), NOP_INSTR, IMEM_DEPTH=64, IMEM_IDX_W.
- No sub-module; the FSM, counter and port mux fit in one module.

Test Plan:
- Reset, then core_pc=0x08 in RUN -> imem_addr=0x08, core_instr=imem_instr, core_stall=0, busy=0.
- load_start with load_count=3, ld_valid high with data 0xA,0xB,0xC -> imem_we high 3 cycles at addresses 0x0,0x4,0x8; next cycle done=1 and core_restart=1; then RUN with stall=0.
- load_count=2 with ld_valid gapped (1,0,0,1) -> exactly 2 writes at 0x0 and 0x4, FLUSH follows the second write, busy high for 5 cycles.
- load_start with load_count=0, then with load_count=65 -> err=1, state stays RUN, no writes.
- reset asserted on the 2nd word of a 5-word load -> next cycle RUN, busy=0, no done pulse, the write on the reset cycle is suppressed.
- With IMEM_BOUNDS_CHK_EN, core_pc=0x100 -> core_instr=0x00000013, err=1. Without it, imem_addr=0x100 is passed through.
